// File: rtl/knn_dist_sched.sv
// knn_dist_sched: streams neighbor vectors into the distance unit and buffers indexed results under credit control
module knn_dist_sched #(
  parameter int NUM_NEIGHBORS = 1000,
  parameter int ADDR_W = 10,
  parameter int DIST_W = 12,
  parameter int DIST_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [63:0]       query_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [63:0]       mem_rdata_i,
  output logic [63:0]       dist_query_o,
  output logic [63:0]       dist_neighbor_o,
  input  logic [DIST_W-1:0] dist_in_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DIST_W-1:0] out_dist_o,
  output logic [ADDR_W-1:0] out_idx_o,
  output logic              out_last_o
);
  localparam int L = DIST_LAT + 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + L + 1) + 1;
  localparam int EW = DIST_W + ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [63:0] query_q;
  logic [L-1:0] tag_v_q;
  logic [ADDR_W-1:0] tag_idx_q [L];
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] fcnt_q, fcnt_d, occ;
  logic push, pop, credit, issue, last_issue;
  // occupancy = in-flight tags + buffered results; a pop this cycle frees one slot early
  always_comb begin
    occ = fcnt_q;
    for (int i = 0; i < L; i++) occ = occ + CW'(tag_v_q[i]);
    push = tag_v_q[L-1];
    pop = out_valid_o & out_ready_i;
    credit = occ < CW'(FIFO_DEPTH) + CW'(pop);
    issue = (state_q == RUN) & credit;
    last_issue = issue & (cnt_q == ADDR_W'(NUM_NEIGHBORS - 1));
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);
  end
  assign busy_o = (state_q == RUN) | (state_q == DRAIN);
  assign done_o = state_q == DONE;
  assign mem_rd_en_o = issue;
  assign mem_addr_o = cnt_q;
  assign dist_query_o = query_q;
  assign dist_neighbor_o = mem_rdata_i;
  assign head = mem_q[rd_q];
  assign out_valid_o = fcnt_q != '0;
  assign out_dist_o = out_valid_o ? head[EW-1 -: DIST_W] : '0;
  assign out_idx_o = out_valid_o ? head[ADDR_W:1] : '0;
  assign out_last_o = out_valid_o & head[0];
  // control FSM: issue addresses in RUN, wait for pipe and FIFO to empty in DRAIN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      query_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          cnt_q <= '0;
          query_q <= query_i;
        end
        RUN: if (issue) begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: if (~|tag_v_q && fcnt_d == '0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // tag valid bits track which pipeline stages carry a live read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tag_v_q <= '0;
    else tag_v_q <= L'({tag_v_q, issue});
  end
  // tag indices ride alongside the valid bits; meaningless when invalid
  always_ff @(posedge clk_i) begin
    tag_idx_q[0] <= cnt_q;
    for (int i = 1; i < L; i++) tag_idx_q[i] <= tag_idx_q[i-1];
  end
  // FIFO pointers and count; credit guarantees push never meets a full FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop) rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
      fcnt_q <= fcnt_d;
    end
  end
  // FIFO storage: distance, index and last flag of each finished neighbor
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {dist_in_i, tag_idx_q[L-1], tag_idx_q[L-1] == ADDR_W'(NUM_NEIGHBORS - 1)};
  end
endmodule
